add8_err_monitor: RTL and testbench
===================================

// Module: add8_err_monitor
// PURPOSE
//  Streaming error-characterisation engine for the 8-bit approximate adders (add8_*).
//  Consumes {A, B, O_approx} samples and compares each against the exact A+B.
//  Accumulates MAE/MSE/WCE/EP/HD statistics in hardware for on-chip sweeps.
//  Sits downstream of the DUT adder, on the results side of the sweep harness.
// PARAMETERS
//  W       8   operand width; the adder output is W+1 bits
//  CNT_W   17  width of the sample and error counters (2^16 exhaustive pairs + 1)
//  ACC_W   40  width of the sum_abs_err, sum_sq_err and sum_hd accumulators
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  clear        in   1      synchronous clear of all statistics (pulse)
//  in_valid     in   1      sample valid
//  in_ready     out  1      engine can accept a sample
//  in_a         in   W      operand A
//  in_b         in   W      operand B
//  in_o         in   W+1    approximate sum under test
//  busy         out  1      samples in flight in the pipeline
//  sample_cnt   out  CNT_W  accepted samples
//  err_cnt      out  CNT_W  samples with in_o != A+B (EP numerator)
//  sum_abs_err  out  ACC_W  sum of |O - (A+B)| (MAE numerator)
//  sum_sq_err   out  ACC_W  sum of (O - (A+B))^2 (MSE numerator)
//  sum_hd       out  ACC_W  sum of popcount(O ^ (A+B)) (HD)
//  wce          out  W+1    maximum |error| seen
//  sat          out  1      sticky: a counter or accumulator saturated
// BEHAVIOUR
//  - Reset: every output except in_ready = 0; in_ready = 1 in the cycle after rst deasserts.
//  - Handshake: a sample is accepted when in_valid && in_ready. in_ready = !clear, with no other backpressure.
//  - Pipeline, 2 stages.
//    - S1 registers exact = A+B (W+1 bits), e = in_o - exact (signed W+2 bits), |e|, e^2 (2W+2 bits), popcount(in_o ^ exact).
//    - S2 updates the accumulators.
//    - A sample accepted in cycle t is visible on the outputs at t+2.
//  - busy = S1 valid | S2 valid.
//  - Updates per sample:
//    - sample_cnt += 1
//    - err_cnt += (e != 0)
//    - sum_abs_err += |e|
//    - sum_sq_err += e^2
//    - sum_hd += hd
//    - wce = max(wce, |e|)
//  - Saturation: each counter and accumulator clamps at all-ones and does not wrap. The first clamp sets sat, which stays set until clear or rst.
//  - clear: zeros all statistics and sat, and flushes both pipeline stages. Samples in flight are dropped. clear has priority over an update in the same cycle.
//  - rst mid-sweep: same effect as clear, plus in_ready drops for the reset cycle.
//  - Back-to-back samples at one per cycle are sustained indefinitely.
//  - |e| reaches at most 2^(W+1)-1. Widths are sized so no intermediate truncates.
// STRUCTURE
//  - Package add8_err_pkg:
//    - W, CNT_W, ACC_W defaults
//    - typedef err_sample_t {exact, abs_err, sq_err, hd, nz}
//    - function popcount9
//  - Sub-module add8_err_stage: combinational error and S1 register, emitting err_sample_t + valid.
//  - The top holds the S2 accumulators, the saturation logic and clear control.
// TESTING
//  - Exact samples: A=100,B=27,O=127 -> sample_cnt=1, err_cnt=0, sum_abs_err=0, wce=0 at t+2.
//  - Single error: A=3,B=5,O=0 -> |e|=8, sum_sq_err=64, sum_hd=1, err_cnt=1, wce=8.
//  - Max error: A=255,B=255,O=0 -> |e|=510, sq=260100, hd=8, wce=510.
//  - Exhaustive sweep of 65536 pairs with a model adder:
//    - totals match the software reference bit-exactly
//    - sample_cnt = 65536
//    - sat = 0
//  - clear asserted while 2 samples are in flight -> all stats = 0 the next cycle, in_ready = 0 during clear, dropped samples are not counted.
//  - Saturation: ACC_W=8, feed 2 samples with |e|=200 -> sum_abs_err=255, sat=1; sat persists until clear.

Source files
------------

// File: rtl/add8_err_pkg.sv
// Shared widths, the per-sample error record and helpers for the add8 error monitor.
// W is fixed at 8 because the record layout and popcount9 are sized for a 9-bit sum.
package add8_err_pkg;

  localparam int W         = 8;
  localparam int DEF_CNT_W = 17;
  localparam int DEF_ACC_W = 40;
  localparam int SQ_W      = 2 * W + 2;
  localparam int HD_W      = 4;

  typedef struct packed {
    logic [W:0]      exact;
    logic [W:0]      abs_err;
    logic [SQ_W-1:0] sq_err;
    logic [HD_W-1:0] hd;
    logic            nz;
  } err_sample_t;

  function automatic logic [HD_W-1:0] popcount9(input logic [W:0] v);
    logic [HD_W-1:0] n;
    n = '0;
    for (int i = 0; i <= W; i++) begin
      n = n + HD_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/add8_err_stage.sv
// First pipeline stage: exact sum, error magnitude, square and Hamming distance,
// registered together with a valid flag. flush_i drops whatever is held.
module add8_err_stage
  import add8_err_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W:0]  o_i,
  output err_sample_t sample_o,
  output logic        valid_o
);

  logic [W:0]   exact;
  logic [W+1:0] err;
  logic [W+1:0] err_neg;
  logic [W:0]   abs_err;
  err_sample_t  sample_d;
  err_sample_t  sample_q;
  logic         valid_q;

  always_comb begin
    exact   = {1'b0, a_i} + {1'b0, b_i};
    // Two's-complement difference in W+2 bits; the MSB is the sign.
    err     = {1'b0, o_i} - {1'b0, exact};
    err_neg = '0 - err;
    abs_err = err[W+1] ? err_neg[W:0] : err[W:0];

    sample_d         = '0;
    sample_d.exact   = exact;
    sample_d.abs_err = abs_err;
    sample_d.sq_err  = SQ_W'(abs_err) * SQ_W'(abs_err);
    sample_d.hd      = popcount9(o_i ^ exact);
    sample_d.nz      = (err != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      valid_q  <= valid_i;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/add8_err_monitor.sv
// Streaming error-statistics engine for 8-bit approximate adders: a two-stage
// pipeline whose second stage folds each sample into saturating counters.
module add8_err_monitor
  import add8_err_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_o,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [ACC_W-1:0] sum_sq_err,
  output logic [ACC_W-1:0] sum_hd,
  output logic [W:0]       wce,
  output logic             sat
);

  // One spare bit above the widest operand catches every overflow.
  localparam int SW  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam int CSW = CNT_W + 1;

  err_sample_t      s1;
  logic             s1_valid;
  logic             s2_valid_q;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [W:0]       wce_q, wce_d;
  logic             sat_q, sat_d;
  logic [CSW-1:0]   smp_sum, err_sum;
  logic [SQ_W-1:0]  acc_inc [3];
  logic [ACC_W-1:0] acc_out [3];
  logic [2:0]       acc_ovf;
  logic             unused_exact;

  assign in_ready = !(clear || rst);

  add8_err_stage u_stage (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (clear),
    .valid_i  (in_valid && in_ready),
    .a_i      (in_a),
    .b_i      (in_b),
    .o_i      (in_o),
    .sample_o (s1),
    .valid_o  (s1_valid)
  );

  assign unused_exact = ^s1.exact;

  assign acc_inc[0] = SQ_W'(s1.abs_err);
  assign acc_inc[1] = s1.sq_err;
  assign acc_inc[2] = SQ_W'(s1.hd);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_acc
      logic [SW-1:0]    sum;
      logic             ovf;
      logic [ACC_W-1:0] acc_d;
      logic [ACC_W-1:0] acc_q;

      always_comb begin
        sum   = SW'(acc_q) + SW'(acc_inc[gi]);
        ovf   = s1_valid && (sum[SW-1:ACC_W] != '0);
        acc_d = acc_q;
        if (s1_valid) begin
          acc_d = ovf ? '1 : sum[ACC_W-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end

      assign acc_out[gi] = acc_q;
      assign acc_ovf[gi] = ovf;
    end
  endgenerate

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    wce_d        = wce_q;
    sat_d        = sat_q;
    smp_sum      = {1'b0, sample_cnt_q} + CSW'(1);
    err_sum      = {1'b0, err_cnt_q} + CSW'(s1.nz);
    if (s1_valid) begin
      sample_cnt_d = smp_sum[CSW-1] ? '1 : smp_sum[CNT_W-1:0];
      err_cnt_d    = err_sum[CSW-1] ? '1 : err_sum[CNT_W-1:0];
      if (s1.abs_err > wce_q) begin
        wce_d = s1.abs_err;
      end
      sat_d = sat_q || smp_sum[CSW-1] || err_sum[CSW-1] || (acc_ovf != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      wce_q        <= '0;
      sat_q        <= 1'b0;
      s2_valid_q   <= 1'b0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      wce_q        <= wce_d;
      sat_q        <= sat_d;
      s2_valid_q   <= s1_valid;
    end
  end

  assign busy        = s1_valid || s2_valid_q;
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign sum_abs_err = acc_out[0];
  assign sum_sq_err  = acc_out[1];
  assign sum_hd      = acc_out[2];
  assign wce         = wce_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor: latency, single samples, extremes,
// clear with samples in flight, an exhaustive LOA-adder sweep and saturation.
module tb_add8_err_monitor;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid;
  logic [7:0]  in_a, in_b;
  logic [8:0]  in_o;

  logic        in_ready, busy, sat;
  logic [16:0] sample_cnt, err_cnt;
  logic [39:0] sum_abs_err, sum_sq_err, sum_hd;
  logic [8:0]  wce;

  logic        s_in_ready, s_busy, s_sat;
  logic [16:0] s_sample_cnt, s_err_cnt;
  logic [7:0]  s_sum_abs_err, s_sum_sq_err, s_sum_hd;
  logic [8:0]  s_wce;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add8_err_monitor dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o), .busy(busy), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err),
    .sum_hd(sum_hd), .wce(wce), .sat(sat)
  );

  add8_err_monitor #(.CNT_W(17), .ACC_W(8)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o), .busy(s_busy), .sample_cnt(s_sample_cnt),
    .err_cnt(s_err_cnt), .sum_abs_err(s_sum_abs_err), .sum_sq_err(s_sum_sq_err),
    .sum_hd(s_sum_hd), .wce(s_wce), .sat(s_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Present one sample for exactly one accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
    in_a = a; in_b = b; in_o = o; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("sample a=%0d b=%0d o=%0d", a, b, o);
  endtask

  // Lower-part OR adder: exact upper nibble sum, OR of the low nibbles.
  function automatic logic [8:0] loa(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] hi;
    hi = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    return {hi, a[3:0] | b[3:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_o = '0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0b want 0", in_ready); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %0b want 1", in_ready); end
    checks++; if ({busy, sat, sample_cnt, err_cnt, wce} !== '0) begin errors++; $display("FAIL reset_ctrs: got busy=%0b sat=%0b cnt=%0d err=%0d wce=%0d want all 0", busy, sat, sample_cnt, err_cnt, wce); end
    checks++; if ({sum_abs_err, sum_sq_err, sum_hd} !== '0) begin errors++; $display("FAIL reset_accs: got abs=%0d sq=%0d hd=%0d want 0", sum_abs_err, sum_sq_err, sum_hd); end
    $display("test_reset done");
  endtask

  task automatic test_exact();
    send(8'd100, 8'd27, 9'd127);
    checks++; if (sample_cnt !== 17'd0) begin errors++; $display("FAIL exact_latency: got cnt=%0d want 0", sample_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exact_busy: got %0b want 1", busy); end
    tick();
    checks++; if (sample_cnt !== 17'd1) begin errors++; $display("FAIL exact_cnt: got %0d want 1", sample_cnt); end
    checks++; if (err_cnt !== 17'd0 || sum_abs_err !== 40'd0 || wce !== 9'd0) begin errors++; $display("FAIL exact_stats: got err=%0d abs=%0d wce=%0d want 0", err_cnt, sum_abs_err, wce); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exact_idle: got busy=%0b want 0", busy); end
  endtask

  task automatic test_single_error();
    do_clear();
    send(8'd3, 8'd5, 9'd0);
    tick();
    checks++; if (err_cnt !== 17'd1) begin errors++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt); end
    checks++; if (sum_abs_err !== 40'd8) begin errors++; $display("FAIL single_abs: got %0d want 8", sum_abs_err); end
    checks++; if (sum_sq_err !== 40'd64) begin errors++; $display("FAIL single_sq: got %0d want 64", sum_sq_err); end
    checks++; if (sum_hd !== 40'd1) begin errors++; $display("FAIL single_hd: got %0d want 1", sum_hd); end
    checks++; if (wce !== 9'd8) begin errors++; $display("FAIL single_wce: got %0d want 8", wce); end
  endtask

  task automatic test_max_error();
    do_clear();
    send(8'd255, 8'd255, 9'd0);
    tick();
    checks++; if (sum_abs_err !== 40'd510 || wce !== 9'd510) begin errors++; $display("FAIL max_abs: got abs=%0d wce=%0d want 510", sum_abs_err, wce); end
    checks++; if (sum_sq_err !== 40'd260100) begin errors++; $display("FAIL max_sq: got %0d want 260100", sum_sq_err); end
    checks++; if (sum_hd !== 40'd8) begin errors++; $display("FAIL max_hd: got %0d want 8", sum_hd); end
    // Positive extreme: exact 0, O = 511.
    send(8'd0, 8'd0, 9'd511);
    tick();
    checks++; if (sample_cnt !== 17'd2 || err_cnt !== 17'd2) begin errors++; $display("FAIL pos_cnt: got cnt=%0d err=%0d want 2 2", sample_cnt, err_cnt); end
    checks++; if (sum_abs_err !== 40'd1021 || wce !== 9'd511) begin errors++; $display("FAIL pos_abs: got abs=%0d wce=%0d want 1021 511", sum_abs_err, wce); end
    checks++; if (sum_sq_err !== 40'd521221 || sum_hd !== 40'd17) begin errors++; $display("FAIL pos_sq_hd: got sq=%0d hd=%0d want 521221 17", sum_sq_err, sum_hd); end
  endtask

  task automatic test_clear_inflight();
    do_clear();
    in_valid = 1'b1;
    in_a = 8'd3; in_b = 8'd5; in_o = 9'd0;
    tick();
    in_a = 8'd10; in_b = 8'd10; in_o = 9'd0;
    tick();
    checks++; if (sample_cnt !== 17'd1) begin errors++; $display("FAIL clr_pre_cnt: got %0d want 1", sample_cnt); end
    clear = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %0b want 0", in_ready); end
    tick();
    checks++; if ({sample_cnt, err_cnt, wce, sat, busy} !== '0) begin errors++; $display("FAIL clr_ctrs: got cnt=%0d err=%0d wce=%0d sat=%0b busy=%0b want 0", sample_cnt, err_cnt, wce, sat, busy); end
    checks++; if ({sum_abs_err, sum_sq_err, sum_hd} !== '0) begin errors++; $display("FAIL clr_accs: got abs=%0d sq=%0d hd=%0d want 0", sum_abs_err, sum_sq_err, sum_hd); end
    clear = 1'b0; in_valid = 1'b0;
    tick(); tick();
    checks++; if (sample_cnt !== 17'd0 || sum_abs_err !== 40'd0) begin errors++; $display("FAIL clr_dropped: got cnt=%0d abs=%0d want 0", sample_cnt, sum_abs_err); end
    $display("test_clear_inflight done");
  endtask

  task automatic test_back_to_back();
    longint r_err, r_abs, r_sq, r_hd, r_wce;
    int e, ae;
    logic [8:0] o, ex;
    r_err = 0; r_abs = 0; r_sq = 0; r_hd = 0; r_wce = 0;
    do_clear();
    in_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        in_a = 8'(a); in_b = 8'(b);
        o  = loa(8'(a), 8'(b));
        ex = 9'(a + b);
        in_o = o;
        e  = int'(o) - (a + b);
        ae = (e < 0) ? -e : e;
        if (e != 0) r_err++;
        r_abs += ae;
        r_sq  += longint'(ae) * ae;
        r_hd  += $countones(o ^ ex);
        if (ae > r_wce) r_wce = ae;
        tick();
      end
    end
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (sample_cnt !== 17'd65536) begin errors++; $display("FAIL sweep_cnt: got %0d want 65536", sample_cnt); end
    checks++; if (err_cnt !== 17'(r_err)) begin errors++; $display("FAIL sweep_err: got %0d want %0d", err_cnt, r_err); end
    checks++; if (sum_abs_err !== 40'(r_abs)) begin errors++; $display("FAIL sweep_abs: got %0d want %0d", sum_abs_err, r_abs); end
    checks++; if (sum_sq_err !== 40'(r_sq)) begin errors++; $display("FAIL sweep_sq: got %0d want %0d", sum_sq_err, r_sq); end
    checks++; if (sum_hd !== 40'(r_hd)) begin errors++; $display("FAIL sweep_hd: got %0d want %0d", sum_hd, r_hd); end
    checks++; if (wce !== 9'(r_wce)) begin errors++; $display("FAIL sweep_wce: got %0d want %0d", wce, r_wce); end
    checks++; if (sat !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sweep_sat_busy: got sat=%0b busy=%0b want 0 0", sat, busy); end
    $display("sweep of 65536 pairs: err=%0d abs=%0d sq=%0d hd=%0d wce=%0d", r_err, r_abs, r_sq, r_hd, r_wce);
  endtask

  task automatic test_saturation();
    do_clear();
    in_valid = 1'b1; in_a = 8'd0; in_b = 8'd0; in_o = 9'd200;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (s_sum_abs_err !== 8'd255) begin errors++; $display("FAIL sat_abs: got %0d want 255", s_sum_abs_err); end
    checks++; if (s_sat !== 1'b1) begin errors++; $display("FAIL sat_flag: got %0b want 1", s_sat); end
    checks++; if (sum_abs_err !== 40'd400 || sat !== 1'b0) begin errors++; $display("FAIL sat_wide: got abs=%0d sat=%0b want 400 0", sum_abs_err, sat); end
    repeat (3) tick();
    checks++; if (s_sat !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %0b want 1", s_sat); end
    do_clear();
    checks++; if (s_sat !== 1'b0 || s_sum_abs_err !== 8'd0) begin errors++; $display("FAIL sat_cleared: got sat=%0b abs=%0d want 0 0", s_sat, s_sum_abs_err); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_exact();
    test_single_error();
    test_max_error();
    test_clear_inflight();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
